mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits; SHALL be at least 2.
REQ-002 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles; SHALL be at least 1.
REQ-003 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles; SHALL be at least 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  op request, sampled on a rising clk edge.
REQ-007 op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in mdu_pkg).
REQ-008 A  input  WIDTH  operand A, or the write data for MTHI/MTLO.
REQ-009 B  input  WIDTH  operand B.
REQ-010 busy  output  1  multi-cycle op in progress.
REQ-011 done  output  1  one-cycle pulse in the cycle HI/LO take a multi-cycle result.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.

Function
REQ-014 FSM SHALL have two states: IDLE and RUN.
REQ-015 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch A, B and op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-016 In RUN, the counter SHALL decrement each cycle; at the edge where it reaches zero, hi/lo SHALL update, state SHALL return to IDLE, and done SHALL be high for the following cycle.
REQ-017 busy SHALL equal (state == RUN); with start at edge k, busy SHALL be high for exactly N cycles and hi/lo SHALL be valid after edge k+N.
REQ-018 In IDLE, start with MTHI/MTLO SHALL write A to hi/lo at that edge, with no busy and no done.
REQ-019 start SHALL be ignored while busy, for every op; latched operands SHALL be unaffected.
REQ-020 start in the same cycle as done SHALL be accepted, since the state is IDLE by then.
REQ-021 MULT SHALL compute the signed 2*WIDTH-bit product, and MULTU the unsigned product; {hi,lo} SHALL equal the product.
REQ-022 DIV and DIVU SHALL write the quotient to lo and the remainder to hi; DIV SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-023 Divide by zero (DIV or DIVU) SHALL give lo = all ones and hi = A.
REQ-024 DIV overflow (A = most-negative, B = -1) SHALL give lo = A and hi = 0.
REQ-025 Unused op encodings with start SHALL be no-ops.

Reset
REQ-026 While reset is asserted, the block SHALL immediately force the state to IDLE, the counter to 0, busy = 0, done = 0, hi = 0 and lo = 0, regardless of clk.
REQ-027 Reset during RUN SHALL abort the op; no result SHALL be written after reset is released.

Structure
REQ-028 Package mdu_pkg SHALL hold the op encodings, the FSM state typedef and the counter width, defined as clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
REQ-029 Results SHALL be computed combinationally from the latched operands and registered at completion.
REQ-030 No sub-module is required; counter and FSM SHALL be inline.

Verification
REQ-031 Run MULT A=0xFFFFFFFD (-3), B=5 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
REQ-032 Run DIVU A=7, B=2, then DIV A=0xFFFFFFF9 (-7), B=2 -> lo=3, hi=1, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, each after 10 busy cycles.
REQ-033 Run DIV A=0x10, B=0, then DIV A=0x80000000, B=0xFFFFFFFF -> hi=0x10, lo=0xFFFFFFFF, then lo=0x80000000, hi=0.
REQ-034 Issue MTHI A=0x1234 while busy from MULTU 2*3 -> MTHI ignored; after completion hi=0, lo=6; MTHI issued in IDLE -> hi=0x1234 next cycle.
REQ-035 Assert reset at cycle 3 of DIVU -> busy, hi and lo go to 0 immediately; after release they stay 0 and no done occurs.
REQ-036 Issue a back-to-back start in the done cycle -> the second op is accepted and busy is re-asserted the next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the counter width helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Wide enough to hold the longer of the two busy durations.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    if (mult_cycles > div_cycles) longest = mult_cycles;
    else                          longest = div_cycles;
    return $clog2(longest + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_MULT_CYCLES, DEF_DIV_CYCLES);

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Results are formed combinationally from latched operands and captured on completion.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  op_e              op_q, op_d;
  logic             done_q, done_d;

  logic             start_long, run_last;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

  assign start_long = start && (op == OP_MULT || op == OP_MULTU ||
                                op == OP_DIV  || op == OP_DIVU);
  assign run_last   = (state_q == ST_RUN) && (cnt_q <= CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_long) state_d = ST_RUN;
      ST_RUN:  if (run_last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Signed product via sign-extension: the low 2*WIDTH bits are exact.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
    a_mag  = a_neg ? ('0 - a_q) : a_q;
    b_mag  = b_neg ? ('0 - b_q) : b_q;
    b_safe = (b_q == '0) ? W_ONE : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? ('0 - uq) : uq;
    rem    = a_neg ? ('0 - ur) : ur;
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q == '0) begin
          res_hi = a_q;
          res_lo = '1;
        end else if (op_q == OP_DIV && a_q == MOST_NEG && b_q == '1) begin
          res_hi = '0;
          res_lo = a_q;
        end else begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            a_d = A; b_d = B; op_d = op_e'(op); cnt_d = MULT_LOAD;
          end
          OP_DIV, OP_DIVU: begin
            a_d = A; b_d = B; op_d = op_e'(op); cnt_d = DIV_LOAD;
          end
          OP_MTHI: hi_d = A;
          OP_MTLO: lo_d = A;
          default: ;
        endcase
      end
    end else if (run_last) begin
      cnt_d  = '0;
      hi_d   = res_hi;
      lo_d   = res_lo;
      done_d = 1'b1;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: multiply, divide, special divides,
// MTHI/MTLO, reset abort and back-to-back issue.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Caller sits on a negedge; returns on the negedge after busy drops.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
    #2;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, n);
    vectors++; if (n !== 5) begin miscompares++; $display("[TB] FAIL mult_busy got %0d want 5", n); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_done got %b want 1", done); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL mult_hi got %h want ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFF_FFF1) begin miscompares++; $display("[TB] FAIL mult_lo got %h want fffffff1", lo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_done_pulse got %b want 0", done); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("[TB] FAIL multu_hi got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(OP_DIVU, 32'd7, 32'd2, n);
    vectors++; if (n !== 10) begin miscompares++; $display("[TB] FAIL divu_busy got %0d want 10", n); end
    vectors++; if (lo !== 32'd3) begin miscompares++; $display("[TB] FAIL divu_lo got %h want 3", lo); end
    vectors++; if (hi !== 32'd1) begin miscompares++; $display("[TB] FAIL divu_hi got %h want 1", hi); end
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    vectors++; if (n !== 10) begin miscompares++; $display("[TB] FAIL div_busy got %0d want 10", n); end
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("[TB] FAIL div_lo got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL div_hi got %h want ffffffff", hi); end
    @(negedge clk);
  endtask

  task automatic test_div_special();
    int n;
    run_op(OP_DIV, 32'h10, 32'h0, n);
    vectors++; if (hi !== 32'h10) begin miscompares++; $display("[TB] FAIL div0_hi got %h want 10", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL div0_lo got %h want ffffffff", lo); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL divovf_lo got %h want 80000000", lo); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("[TB] FAIL divovf_hi got %h want 0", hi); end
    run_op(OP_DIVU, 32'h5, 32'h0, n);
    vectors++; if (hi !== 32'h5) begin miscompares++; $display("[TB] FAIL divu0_hi got %h want 5", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL divu0_lo got %h want ffffffff", lo); end
    @(negedge clk);
  endtask

  task automatic test_move_while_busy();
    int n;
    start = 1'b1; op = OP_MULTU; A = 32'd2; B = 32'd3;
    @(negedge clk);
    op = OP_MTHI; A = 32'h1234; B = 32'h0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      start = 1'b0;
    end
    vectors++; if (n !== 5) begin miscompares++; $display("[TB] FAIL mtbusy_busy got %0d want 5", n); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("[TB] FAIL mtbusy_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd6) begin miscompares++; $display("[TB] FAIL mtbusy_lo got %h want 6", lo); end
    start = 1'b1; op = OP_MTHI; A = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (hi !== 32'h1234) begin miscompares++; $display("[TB] FAIL mthi_hi got %h want 1234", hi); end
    vectors++; if (lo !== 32'd6) begin miscompares++; $display("[TB] FAIL mthi_lo got %h want 6", lo); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL mthi_flags got %b%b want 00", busy, done); end
    start = 1'b1; op = OP_MTLO; A = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (lo !== 32'hABCD) begin miscompares++; $display("[TB] FAIL mtlo_lo got %h want abcd", lo); end
    start = 1'b1; op = 3'd7; A = 32'h5555; B = 32'h7;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (hi !== 32'h1234 || lo !== 32'hABCD || busy !== 1'b0)
      begin miscompares++; $display("[TB] FAIL unused_op got hi=%h lo=%h busy=%b want 1234 abcd 0", hi, lo, busy); end
  endtask

  task automatic test_reset_run();
    int done_seen;
    start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rstrun_pre_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstrun_busy got %b want 0", busy); end
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("[TB] FAIL rstrun_hilo got %h %h want 0 0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("[TB] FAIL rstrun_after got %0d done/busy cycles want 0", done_seen); end
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("[TB] FAIL rstrun_after_hilo got %h %h want 0 0", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    run_op(OP_MULTU, 32'd2, 32'd3, n);
    vectors++; if (done !== 1'b1 || lo !== 32'd6) begin miscompares++; $display("[TB] FAIL b2b_first got done=%b lo=%h want 1 6", done, lo); end
    run_op(OP_MULTU, 32'd7, 32'd6, n);
    vectors++; if (n !== 5) begin miscompares++; $display("[TB] FAIL b2b_busy got %0d want 5", n); end
    vectors++; if (lo !== 32'd42 || hi !== 32'h0) begin miscompares++; $display("[TB] FAIL b2b_result got %h %h want 0 2a", hi, lo); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_move_while_busy();
    test_reset_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
